// File: rtl/mem_addr_scanner.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_scanner
// Description : Request-side initiator for the memory address-check
//               interface. Walks a contiguous address range, issuing one
//               single-cycle valid per address back-to-back, samples each
//               v_err response RSP_LAT cycles later and reports error count,
//               first failing address and completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_scanner #(
    parameter int AW      = 8,  // address width
    parameter int CW      = 9,  // range count / error counter width
    parameter int RSP_LAT = 1   // valid-to-v_err sample latency, 1..8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] num_addr,
    input  logic          stop_on_err,
    output logic [AW-1:0] addr,
    output logic          valid,
    input  logic          v_err,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] err_cnt,
    output logic          err_seen,
    output logic [AW-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Saturation limit of the error counter.
    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
    // Selects every tag stage except the output end; a set bit there means
    // a request is still outstanding beyond the one sampled this cycle.
    localparam logic [RSP_LAT-1:0] c_body_mask = {RSP_LAT{1'b1}} >> 1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_valid;
    logic          w_valid_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [CW-1:0] r_remaining;      // requests still to issue after r_addr
    logic [CW-1:0] w_remaining_nxt;
    logic          r_stop_on_err;
    logic          w_accept;

    // Outstanding-request tracker: stage 0 is the newest request.
    logic [RSP_LAT-1:0] r_tag_v;
    logic [AW-1:0]      r_tag_addr [RSP_LAT];

    logic          w_sample;
    logic          w_err_hit;
    logic          w_first_err;
    logic          w_halt;
    logic          w_inflight;

    logic [CW-1:0] r_err_cnt;
    logic          r_err_seen;
    logic [AW-1:0] r_first_err_addr;

    // ------------------------------------------------------------------
    // Response sampling
    // ------------------------------------------------------------------
    // v_err only means something when the oldest tag holds a real request.
    assign w_sample    = r_tag_v[RSP_LAT-1];
    assign w_err_hit   = w_sample & v_err;
    assign w_first_err = w_err_hit & ~r_err_seen;
    // Issue halts from the cycle after the first sampled error.
    assign w_halt      = r_stop_on_err & w_first_err;
    assign w_inflight  = |(r_tag_v & c_body_mask);

    // ------------------------------------------------------------------
    // Outstanding-request shift register
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < RSP_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // Capture the request presented on the bus this cycle.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_tag_v[gi]    <= 1'b0;
                        r_tag_addr[gi] <= '0;
                    end else begin
                        r_tag_v[gi]    <= r_valid;
                        r_tag_addr[gi] <= r_addr;
                    end
                end
            end else begin : g_body
                // Age the request by one cycle towards the sample point.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_tag_v[gi]    <= 1'b0;
                        r_tag_addr[gi] <= '0;
                    end else begin
                        r_tag_v[gi]    <= r_tag_v[gi-1];
                        r_tag_addr[gi] <= r_tag_addr[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // Next-state and next request-bus values; valid defaults low so it can
    // only be asserted from IDLE (first request) or ISSUE.
    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = 1'b0;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_accept        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (num_addr != '0) begin
                        w_state_nxt     = S_ISSUE;
                        w_valid_nxt     = 1'b1;
                        w_addr_nxt      = base_addr;
                        w_remaining_nxt = num_addr - CW'(1);
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if ((r_remaining != '0) && !w_halt) begin
                    w_valid_nxt     = 1'b1;
                    w_addr_nxt      = r_addr + AW'(1);  // wraps modulo 2^AW
                    w_remaining_nxt = r_remaining - CW'(1);
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_inflight) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and request-bus registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_valid       <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_stop_on_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            if (w_accept) begin
                r_stop_on_err <= stop_on_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    // Cleared by an accepted start, updated on each sampled error, and
    // otherwise held so results remain readable after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt        <= '0;
            r_err_seen       <= 1'b0;
            r_first_err_addr <= '0;
        end else if (w_accept) begin
            r_err_cnt        <= '0;
            r_err_seen       <= 1'b0;
            r_first_err_addr <= '0;
        end else if (w_err_hit) begin
            if (r_err_cnt != c_cnt_max) begin
                r_err_cnt <= r_err_cnt + CW'(1);
            end
            if (!r_err_seen) begin
                r_err_seen       <= 1'b1;
                r_first_err_addr <= r_tag_addr[RSP_LAT-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign addr           = r_addr;
    assign valid          = r_valid;
    assign busy           = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign err_cnt        = r_err_cnt;
    assign err_seen       = r_err_seen;
    assign first_err_addr = r_first_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_addr_scanner
// Description : Directed self-checking bench for mem_addr_scanner with a
//               response latency of 2. Each scan is described by its inputs
//               plus hand-computed expected valid count, done cycle and
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_addr_scanner;

    localparam int AW  = 8;
    localparam int CW  = 9;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_addr;
    logic          stop_on_err;
    logic [AW-1:0] addr;
    logic          valid;
    logic          v_err;
    logic          busy;
    logic          done;
    logic [CW-1:0] err_cnt;
    logic          err_seen;
    logic [AW-1:0] first_err_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_addr_scanner #(
        .AW      (AW),
        .CW      (CW),
        .RSP_LAT (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_addr       (num_addr),
        .stop_on_err    (stop_on_err),
        .addr           (addr),
        .valid          (valid),
        .v_err          (v_err),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .err_seen       (err_seen),
        .first_err_addr (first_err_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".addr"},  addr, 0);
        check({tag, ".valid"}, valid, 0);
        check({tag, ".busy"},  busy, 0);
        check({tag, ".done"},  done, 0);
        check({tag, ".cnt"},   err_cnt, 0);
        check({tag, ".seen"},  err_seen, 0);
        check({tag, ".first"}, first_err_addr, 0);
    endtask

    // One scan. emask bit i makes request i answer with an error; v_err is
    // driven high in every cycle that carries no real response to prove it
    // is ignored there. poke re-pulses start mid-scan and in the done cycle.
    task automatic run_scan(input logic [7:0] base, input logic [8:0] n,
                            input logic stop, input logic [15:0] emask,
                            input bit poke, input int exp_nv, input int exp_done,
                            input logic [8:0] exp_cnt, input logic exp_seen,
                            input logic [7:0] exp_first);
        int          r;
        logic [7:0]  a;
        start       = 1'b1;
        base_addr   = base;
        num_addr    = n;
        stop_on_err = stop;
        v_err       = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            r     = cyc - LAT - 1;
            v_err = (r >= 0 && r < exp_nv) ? emask[r] : 1'b1;
            if (poke) begin
                start     = (cyc == 2) || (cyc == exp_done);
                base_addr = 8'h80;
                num_addr  = 9'd3;
            end
            check("valid", valid, cyc <= exp_nv);
            if (cyc <= exp_nv) begin
                a = base + 8'(cyc - 1);
                check("addr", addr, a);
            end
            check("busy", busy, cyc < exp_done);
            check("done", done, cyc == exp_done);
            if (cyc < exp_done) tick();
        end
        check("err_cnt", err_cnt, exp_cnt);
        check("err_seen", err_seen, exp_seen);
        check("first_err", first_err_addr, exp_first);
        tick();
        start = 1'b0;
        v_err = 1'b0;
        check("idle.valid", valid, 0);
        check("idle.busy", busy, 0);
        check("idle.done", done, 0);
        tick();
        check("hold.valid", valid, 0);
        check("hold.cnt", err_cnt, exp_cnt);
        check("hold.first", first_err_addr, exp_first);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        base_addr   = 8'h10;
        num_addr    = 9'd4;
        stop_on_err = 1'b0;
        v_err       = 1'b0;

        // Reset held two cycles with start asserted.
        tick();
        check_reset_vals("rst1");
        tick();
        check_reset_vals("rst2");
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("rst3.valid", valid, 0);
        check("rst3.busy", busy, 0);

        // Clean scan 0x10..0x13.
        run_scan(8'h10, 9'd4, 1'b0, 16'h0000, 1'b0, 4, 7, 9'd0, 1'b0, 8'h00);

        // v_err in IDLE is not counted.
        v_err = 1'b1;
        tick();
        tick();
        v_err = 1'b0;
        check("idle_verr.cnt", err_cnt, 0);
        check("idle_verr.seen", err_seen, 0);

        // Errors on 0x02 and 0x04.
        run_scan(8'h01, 9'd4, 1'b0, 16'b1010, 1'b0, 4, 7, 9'd2, 1'b1, 8'h02);

        // Stop on error at 0x21; 0x23 is in flight and errors too.
        run_scan(8'h20, 9'd8, 1'b1, 16'b1010, 1'b0, 4, 7, 9'd2, 1'b1, 8'h21);

        // Address wrap, error on 0x01.
        run_scan(8'hFE, 9'd4, 1'b0, 16'b1000, 1'b0, 4, 7, 9'd1, 1'b1, 8'h01);

        // Zero-length scan clears previous results.
        run_scan(8'h33, 9'd0, 1'b0, 16'h0000, 1'b0, 0, 1, 9'd0, 1'b0, 8'h00);

        // start pulsed mid-scan and in the done cycle.
        run_scan(8'h40, 9'd5, 1'b0, 16'h0000, 1'b1, 5, 8, 9'd0, 1'b0, 8'h00);

        // Reset in cycle 3 of a 6-address scan, while an error is sampled.
        start       = 1'b1;
        base_addr   = 8'h50;
        num_addr    = 9'd6;
        stop_on_err = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid.valid", valid, 1);
        check("mid.addr", addr, 8'h52);
        reset = 1'b1;
        v_err = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        v_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("post_rst.done", done, 0);
            check("post_rst.valid", valid, 0);
            tick();
        end

        // Fresh scan after reset.
        run_scan(8'h60, 9'd3, 1'b0, 16'b0001, 1'b0, 3, 6, 9'd1, 1'b1, 8'h60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_addr_scanner.md
# mem_addr_scanner

Request-side initiator for the memory address-check interface (`addr`/`valid` out, `v_err` back). When started, it walks a contiguous address range and issues one single-cycle `valid` request per address, pipelined back-to-back. It samples each `v_err` response after a fixed latency and reports the error count, the first failing address and completion. It sits between a test/BIST controller and the memory block that answers address-existence queries.

## Interface
Parameters:
- `AW`, 8: address width.
- `CW`, 9: width of range count and error counter.
- `RSP_LAT`, 1: cycles from a `valid` cycle to the cycle its `v_err` is sampled. Legal range is 1..8.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan. Accepted only in IDLE.
- `base_addr`  in  AW  first address. Sampled with an accepted `start`.
- `num_addr`  in  CW  number of addresses to scan. Sampled with an accepted `start`.
- `stop_on_err`  in  1  halt issuing after the first error. Sampled with an accepted `start`.
- `addr`  out  AW  request address, registered.
- `valid`  out  1  request strobe, registered.
- `v_err`  in  1  responder error flag for the request issued RSP_LAT cycles earlier.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when a scan completes.
- `err_cnt`  out  CW  number of error responses, saturating.
- `err_seen`  out  1  at least one error in the current/last scan.
- `first_err_addr`  out  AW  address of the first error response.

## Operation
- Reset values: `addr`=0, `valid`=0, `busy`=0, `done`=0, `err_cnt`=0, `err_seen`=0, `first_err_addr`=0. The FSM enters IDLE and all in-flight tracking is cleared.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start` with `num_addr`≠0.
  - IDLE → DONE on `start` with `num_addr`=0.
  - ISSUE → DRAIN after the last request is issued, or on a stop caused by an error.
  - DRAIN → DONE once no requests are outstanding.
  - DONE → IDLE unconditionally.
- An accepted `start` clears `err_cnt`, `err_seen` and `first_err_addr`, and latches base, count and `stop_on_err`.
- ISSUE drives `valid`=1 on consecutive cycles with `addr`=base+i for i=0..N-1. The address wraps modulo 2^AW (0xFF→0x00 when AW=8).
- A RSP_LAT-deep shift register of {tag valid, addr} tracks outstanding requests. `v_err` is sampled only when the tag at the output end is valid. `v_err` in any other cycle is ignored.
- When an error is sampled:
  - `err_cnt` increments and saturates at 2^CW-1.
  - If `err_seen` was 0, `first_err_addr` takes the tagged address and `err_seen` is set.
- With `stop_on_err`=1, no new `valid` is issued from the cycle after the first error is sampled. Responses already in flight are still sampled and counted.
- `start` while `busy` or in DONE is ignored and causes no state change.
- `reset` asserted mid-scan takes priority over everything. On the next edge all outputs return to reset values and no `done` pulse is produced.
- Results (`err_cnt`, `err_seen`, `first_err_addr`) hold after `done` until the next accepted `start` or `reset`.

## Timing
- `start` is sampled at edge 0. The first `valid`/`addr` appears in cycle 1. For N addresses, `valid` is high in cycles 1..N with no gaps, unless stopped.
- The response for the request in cycle k is sampled in cycle k+RSP_LAT. Updates to the error outputs are visible in cycle k+RSP_LAT+1.
- `busy`=1 in cycles 1..N+RSP_LAT. `done`=1 and `busy`=0 in cycle N+RSP_LAT+1. The block is back in IDLE at N+RSP_LAT+2, and a new `start` is accepted there.
- `num_addr`=0: no `valid` is issued, `busy` stays 0, and `done` pulses in cycle 1.
- Early stop: if the first error is sampled in cycle e, the last `valid` is in cycle e at the latest. `done` pulses in cycle (last valid)+RSP_LAT+1.
- `valid` is never high in IDLE, DRAIN or DONE.

## Test plan
- Reset check: hold `reset` for 2 cycles with `start`=1 → all outputs 0 and no `valid` during or after.
- Clean scan: base=0x10, N=4, RSP_LAT=1, `v_err`=0 → `valid` in cycles 1–4 with `addr` 0x10..0x13, `done` in cycle 6, `err_cnt`=0, `err_seen`=0.
- Error capture: base=0x01, N=4, `v_err`=1 in the response cycles for 0x02 and 0x04 → `err_cnt`=2, `first_err_addr`=0x02, `err_seen`=1. A `v_err` pulse in IDLE is not counted.
- Stop-on-error: base=0x20, N=8, `stop_on_err`=1, RSP_LAT=2, error on 0x21 → `valid` stops after `addr` 0x23 has been issued. 0x22 and 0x23 responses are still sampled. `done` pulses 3 cycles after the last `valid`.
- Wrap and zero-length: base=0xFE, N=4 → `addr` sequence 0xFE, 0xFF, 0x00, 0x01. Then N=0 → `done` in cycle 1 with no `valid`.
- Interference: `start` pulsed mid-scan → ignored, scan unchanged. `reset` in cycle 3 of an N=6 scan → outputs at reset values next cycle, no `done`. A fresh `start` then runs a complete scan.
